shift_ring_counter: RTL and testbench
=====================================

# shift_ring_counter

Parametrised shift-register counter generalising the fixed 4-bit ring counter to WIDTH bits. It has three counting modes (plain ring, Johnson/twisted-ring, self-correcting ring), selectable shift direction, count enable and parallel load. Status outputs report completion of each full period and the one-hot position of the active bit. It is the standard sequencer/phase generator for downstream one-hot FSMs and time-slot selectors.

## Interface
Parameters:
- WIDTH, default 4: number of stages; legal range is WIDTH >= 2.
- CW, default $clog2(2*WIDTH): step counter width; derived, do not override.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  advance one step this cycle
- load  input  1  parallel load of load_data
- load_data  input  WIDTH  pattern loaded when load=1
- mode  input  2  00 ring, 01 Johnson, 10 self-correcting ring, 11 hold
- dir  input  1  0 shift toward MSB (left), 1 shift toward LSB (right)
- q  output  WIDTH  counter state, registered
- wrap  output  1  one-cycle pulse, registered: a full period has completed
- onehot  output  1  combinational: exactly one bit of q is set
- pos  output  $clog2(WIDTH)  combinational: index of the set bit when onehot=1, else 0

## Operation
- Priority at each edge is rst > load > (en and mode != 11) > hold.
- rst: q = 0…01 (bit 0 set), step_cnt = 0, wrap = 0.
- load: q = load_data, step_cnt = 0, wrap = 0. No shift occurs that cycle, regardless of en.
- Shift rules apply when en=1 and the block is neither in load nor in reset.
  - Ring, left: q = {q[W-2:0], q[W-1]}.
  - Ring, right: q = {q[0], q[W-1:1]}.
  - Johnson, left: q = {q[W-2:0], ~q[W-1]}.
  - Johnson, right: q = {~q[0], q[W-1:1]}.
  - Self-correcting, left: q = {q[W-2:0], ~|q[W-2:0]}.
  - Self-correcting, right: q = {~|q[W-1:1], q[W-1:1]}.
  - Self-correcting mode converges from any state, including all-zero and multi-hot, to a one-hot state within WIDTH-1 shifts.
  - Hold (mode 11): q and step_cnt frozen, en ignored, wrap = 0.
- Period P is WIDTH for ring and self-correcting modes, and 2*WIDTH for Johnson mode.
- step_cnt (internal, CW bits) increments on every shift.
  - If step_cnt >= P-1 when a shift occurs, step_cnt returns to 0 and wrap = 1 the next cycle.
  - Otherwise wrap = 0.
  - The >= comparison makes a Johnson-to-ring mode change mid-period wrap on the next shift instead of overrunning.
- Mode and dir may change on any cycle and take effect at the same edge. step_cnt is not cleared on mode or dir change.
- With en=0 and no load or rst: q and step_cnt hold, and wrap = 0.
- onehot and pos are pure decodes of the current q. pos picks the lowest set bit only when onehot=1.

## Timing
- All q and wrap changes occur on the rising edge of clk. There are no combinational paths from inputs to q or wrap.
- Latency is one cycle from en, load or rst to the updated q.
- wrap is high for exactly one cycle, the cycle after the shift that completes the period. With back-to-back periods and en held high, wrap pulses every P cycles.
- onehot and pos are valid in the same cycle as q, after combinational delay.
- A rst asserted mid-period discards step_cnt. The next period starts from 0001 with the full P steps before wrap.

## Test plan
Tests use WIDTH=4.
1. Ring, left: rst, then en=1, mode=00, dir=0 for 6 cycles. Required: q = 0010, 0100, 1000, 0001, 0010, 0100; wrap=1 only in the cycle after q returns to 0001; pos = 1, 2, 3, 0, 1, 2.
2. Load during ring: load=1, load_data=1011 with en=1, then 4 ring-left shifts. Required: q=1011 first (no shift), then 0111, 1110, 1101, 1011; onehot=0 throughout; wrap after the 4th shift.
3. Johnson, left: rst, then mode=01, dir=0, en=1 for 8 cycles. Required: q = 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; single wrap after the 8th shift.
4. Self-correcting recovery: load 0110, then mode=10, dir=0, en=1. Required: q = 1100, 1000, 0001, then a clean one-hot rotation; onehot=1 from the 2nd shift onward. Repeat with load 0000, which must reach 0001 on the 1st shift.
5. Direction, enable and hold: rst, then dir=1 ring shifts. Required: q = 1000, 0100, 0010, 0001. Then en=0 for 3 cycles: q holds. Then mode=11 with en=1: q holds and wrap stays 0.
6. Simultaneous events: rst=1 and load=1 together, which must give q=0001. Then rst=1 mid-Johnson-period, which must give q=0001, and the next wrap must arrive only after 8 further shifts.

Source files
------------

// File: rtl/shift_ring_counter.sv
// -----------------------------------------------------------------------------
// shift_ring_counter
//
// Parametrised WIDTH-stage shift-register counter used as a sequencer / phase
// generator. Three counting modes share one register:
//   mode 00 : plain ring (the active pattern rotates)
//   mode 01 : Johnson / twisted ring (inverted feedback, period 2*WIDTH)
//   mode 10 : self-correcting ring (feedback is the NOR of the stages that
//             are not shifted out, so any start pattern collapses to one-hot)
//   mode 11 : hold
// Shift direction is selectable. A parallel load and a synchronous reset are
// also provided. An internal step counter marks completion of each period.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset (q = 0..01)
//   en         advance one step this cycle
//   load       parallel load of load_data (beats en, loses to rst)
//   load_data  pattern loaded when load = 1
//   mode       counting mode, see above
//   dir        0 = shift toward MSB, 1 = shift toward LSB
//   q          registered counter state
//   wrap       registered one-cycle pulse after the shift that ends a period
//   onehot     combinational: exactly one bit of q is set
//   pos        combinational: index of the set bit when onehot, else 0
// -----------------------------------------------------------------------------
module shift_ring_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(2 * WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_data,
  input  logic [1:0]               mode,
  input  logic                     dir,
  output logic [WIDTH-1:0]         q,
  output logic                     wrap,
  output logic                     onehot,
  output logic [$clog2(WIDTH)-1:0] pos
);

  localparam int PW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_RING     = 2'b00,
    MODE_JOHNSON  = 2'b01,
    MODE_SELFCORR = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  // Last step index of a period: P-1 with P = WIDTH or 2*WIDTH.
  localparam logic [CW-1:0]    RING_LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    JOHNSON_LAST  = CW'(2 * WIDTH - 1);
  localparam logic [WIDTH-1:0] RESET_PATTERN = {{(WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Pattern helpers
  // ---------------------------------------------------------------------------

  // Plain rotation; the bit falling off one end re-enters at the other.
  function automatic logic [WIDTH-1:0] ring_next(input logic [WIDTH-1:0] v,
                                                 input logic             right);
    logic [WIDTH-1:0] r;
    if (right) begin
      r = {v[0], v[WIDTH-1:1]};
    end else begin
      r = {v[WIDTH-2:0], v[WIDTH-1]};
    end
    return r;
  endfunction

  // Twisted ring: the re-entering bit is inverted, doubling the period.
  function automatic logic [WIDTH-1:0] johnson_next(input logic [WIDTH-1:0] v,
                                                    input logic             right);
    logic [WIDTH-1:0] r;
    if (right) begin
      r = {~v[0], v[WIDTH-1:1]};
    end else begin
      r = {v[WIDTH-2:0], ~v[WIDTH-1]};
    end
    return r;
  endfunction

  // Self-correcting ring: a 1 is injected only when every stage that stays
  // in the register is 0. Extra ones are therefore shifted out and never
  // regenerated, and an all-zero register regrows a single one.
  function automatic logic [WIDTH-1:0] selfcorr_next(input logic [WIDTH-1:0] v,
                                                     input logic             right);
    logic [WIDTH-1:0] r;
    if (right) begin
      r = {~|v[WIDTH-1:1], v[WIDTH-1:1]};
    end else begin
      r = {v[WIDTH-2:0], ~|v[WIDTH-2:0]};
    end
    return r;
  endfunction

  // Non-zero and no two bits set: clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    logic nonzero;
    logic single;
    nonzero = (v != {WIDTH{1'b0}});
    single  = ((v & (v - WIDTH'(1))) == {WIDTH{1'b0}});
    return nonzero & single;
  endfunction

  // Index of the lowest set bit (scan from the top so the lowest wins).
  function automatic logic [PW-1:0] lowest_index(input logic [WIDTH-1:0] v);
    logic [PW-1:0] idx;
    idx = {PW{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = PW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [CW-1:0]    step_q;
  logic [CW-1:0]    step_d;
  logic             wrap_q;
  logic             wrap_d;

  mode_e            mode_s;
  logic             shift_s;
  logic [WIDTH-1:0] shifted_s;
  logic [CW-1:0]    last_step_s;
  logic             onehot_s;
  logic [PW-1:0]    pos_s;

  assign mode_s  = mode_e'(mode);
  assign shift_s = en & (mode_s != MODE_HOLD);

  // Candidate shifted pattern and period end for the currently selected mode.
  always_comb begin
    shifted_s   = state_q;
    last_step_s = RING_LAST;
    case (mode_s)
      MODE_RING: begin
        shifted_s   = ring_next(state_q, dir);
        last_step_s = RING_LAST;
      end
      MODE_JOHNSON: begin
        shifted_s   = johnson_next(state_q, dir);
        last_step_s = JOHNSON_LAST;
      end
      MODE_SELFCORR: begin
        shifted_s   = selfcorr_next(state_q, dir);
        last_step_s = RING_LAST;
      end
      MODE_HOLD: begin
        shifted_s   = state_q;
        last_step_s = RING_LAST;
      end
      default: begin
        shifted_s   = state_q;
        last_step_s = RING_LAST;
      end
    endcase
  end

  // Next state: load beats shift; the step counter uses >= so that a switch
  // from the long Johnson period to a shorter one wraps on the next shift
  // instead of running past the end.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    wrap_d  = 1'b0;
    if (load) begin
      state_d = load_data;
      step_d  = {CW{1'b0}};
      wrap_d  = 1'b0;
    end else if (shift_s) begin
      state_d = shifted_s;
      if (step_q >= last_step_s) begin
        step_d = {CW{1'b0}};
        wrap_d = 1'b1;
      end else begin
        step_d = step_q + CW'(1);
        wrap_d = 1'b0;
      end
    end else begin
      state_d = state_q;
      step_d  = step_q;
      wrap_d  = 1'b0;
    end
  end

  // State, step counter and wrap registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_PATTERN;
      step_q  <= {CW{1'b0}};
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  // Status decode of the current pattern.
  always_comb begin
    onehot_s = is_onehot(state_q);
    if (onehot_s) begin
      pos_s = lowest_index(state_q);
    end else begin
      pos_s = {PW{1'b0}};
    end
  end

  assign q      = state_q;
  assign wrap   = wrap_q;
  assign onehot = onehot_s;
  assign pos    = pos_s;

endmodule

// File: tb/tb_shift_ring_counter.sv
// Bench for shift_ring_counter (WIDTH = 4): directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// behavioural model computed with integer arithmetic.
module tb_shift_ring_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_data = 4'b0000;
  logic [1:0]   mode = 2'b00;
  logic         dir = 1'b0;
  logic [W-1:0] q;
  logic         wrap;
  logic         onehot;
  logic [1:0]   pos;

  int n_cmp = 0;
  int n_bad = 0;

  shift_ring_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_data(load_data),
    .mode(mode), .dir(dir), .q(q), .wrap(wrap), .onehot(onehot), .pos(pos)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_q = 4'b0001;
  logic         m_wrap = 1'b0;
  int           m_steps = 0;
  logic         m_valid = 1'b0;

  // Next pattern from integer arithmetic on the value.
  function automatic int model_shift(int v, int m, int d);
    int mask;
    int part;
    mask = (1 << W) - 1;
    case (m)
      0: return (d == 0) ? (((v << 1) | (v >> (W - 1))) & mask)
                         : ((v >> 1) | ((v & 1) << (W - 1)));
      1: return (d == 0) ? (((v << 1) & mask) | (((v >> (W - 1)) & 1) ^ 1))
                         : ((v >> 1) | (((v & 1) ^ 1) << (W - 1)));
      2: begin
        if (d == 0) begin
          part = v & (mask >> 1);
          return (part << 1) | ((part == 0) ? 1 : 0);
        end else begin
          part = v >> 1;
          return part | (((part == 0) ? 1 : 0) << (W - 1));
        end
      end
      default: return v;
    endcase
  endfunction

  function automatic int period(int m);
    return (m == 1) ? 2 * W : W;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q <= 4'b0001; m_steps <= 0; m_wrap <= 1'b0; m_valid <= 1'b1;
    end else if (load) begin
      m_q <= load_data; m_steps <= 0; m_wrap <= 1'b0;
    end else if (en && mode != 2'b11) begin
      m_q <= 4'(model_shift(int'(m_q), int'(mode), int'(dir)));
      if (m_steps + 1 >= period(int'(mode))) begin
        m_steps <= 0; m_wrap <= 1'b1;
      end else begin
        m_steps <= m_steps + 1; m_wrap <= 1'b0;
      end
    end else begin
      m_wrap <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_q", 32'(q), 32'(m_q));
      chk("model_wrap", 32'(wrap), 32'(m_wrap));
      chk("model_onehot", 32'(onehot), ($countones(m_q) == 1) ? 32'd1 : 32'd0);
      chk("model_pos", 32'(pos), ($countones(m_q) == 1) ? 32'($clog2(m_q)) : 32'd0);
    end
  end

  // One clock: drive inputs after a falling edge, return at the next one.
  task automatic cyc(input logic r, input logic l, input logic e,
                     input logic [W-1:0] ld, input logic [1:0] m, input logic d);
    rst = r; load = l; en = e; load_data = ld; mode = m; dir = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W-1:0] exp_q [8];
  int           exp_pos [6];

  initial begin
    @(negedge clk);

    // 1. Ring left after reset.
    cyc(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
    chk("rst_q", 32'(q), 32'h1);
    chk("rst_wrap", 32'(wrap), 32'h0);
    exp_q   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
    exp_pos = '{1, 2, 3, 0, 1, 2};
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 4'b0000, 2'b00, 1'b0);
      chk("ring_l_q", 32'(q), 32'(exp_q[i]));
      chk("ring_l_pos", 32'(pos), 32'(exp_pos[i]));
      chk("ring_l_wrap", 32'(wrap), (i == 3) ? 32'd1 : 32'd0);
    end

    // 2. Load with en high, then ring-left shifts of a multi-hot pattern.
    cyc(1'b0, 1'b1, 1'b1, 4'b1011, 2'b00, 1'b0);
    chk("load_q", 32'(q), 32'hB);
    chk("load_onehot", 32'(onehot), 32'h0);
    exp_q = '{4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 4'b0000, 2'b00, 1'b0);
      chk("load_ring_q", 32'(q), 32'(exp_q[i]));
      chk("load_ring_onehot", 32'(onehot), 32'h0);
      chk("load_ring_wrap", 32'(wrap), (i == 3) ? 32'd1 : 32'd0);
    end

    // 3. Johnson left.
    cyc(1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
    exp_q = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 4'b0000, 2'b01, 1'b0);
      chk("johnson_q", 32'(q), 32'(exp_q[i]));
      chk("johnson_wrap", 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
    end

    // 4. Self-correcting recovery from 0110 and from 0000.
    cyc(1'b0, 1'b1, 1'b0, 4'b0110, 2'b10, 1'b0);
    exp_q = '{4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 4'b0000, 2'b10, 1'b0);
      chk("selfcorr_q", 32'(q), 32'(exp_q[i]));
      chk("selfcorr_onehot", 32'(onehot), (i >= 1) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 2'b10, 1'b0);
    chk("selfcorr_zero_onehot", 32'(onehot), 32'h0);
    chk("selfcorr_zero_pos", 32'(pos), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 4'b0000, 2'b10, 1'b0);
    chk("selfcorr_zero_q", 32'(q), 32'h1);

    // 5. Right shifts, enable low, hold mode.
    cyc(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b1);
    exp_q = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 4'b0000, 2'b00, 1'b1);
      chk("ring_r_q", 32'(q), 32'(exp_q[i]));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b1);
      chk("en_low_q", 32'(q), 32'h1);
      chk("en_low_wrap", 32'(wrap), 32'h0);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 4'b0000, 2'b11, 1'b0);
      chk("hold_q", 32'(q), 32'h1);
      chk("hold_wrap", 32'(wrap), 32'h0);
    end

    // 6. rst with load, then rst mid-Johnson period.
    cyc(1'b1, 1'b1, 1'b1, 4'b1010, 2'b00, 1'b0);
    chk("rst_load_q", 32'(q), 32'h1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 4'b0000, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'b0000, 2'b01, 1'b0);
    chk("mid_rst_q", 32'(q), 32'h1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 4'b0000, 2'b01, 1'b0);
      chk("mid_rst_wrap", 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
    end

    // Randomized traffic; mode is sticky so periods can complete.
    begin
      logic [1:0] m;
      logic       d;
      m = 2'b00;
      d = 1'b0;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 9) == 0) m = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) d = 1'($urandom_range(0, 1));
        cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 4) != 0), 4'($urandom), m, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
